// File: rtl/wts_noise_sweep_controller.sv
// Noise frequency sweep sequencer: steps the noise generator frequency count
// from a start value toward an end value at a programmable rate of active pulses.
module wts_noise_sweep_controller #(
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       wr,
  input  logic [1:0] address,
  input  logic [7:0] wdata,
  output logic [4:0] freq_count,
  output logic       noise_enable,
  output logic       busy,
  output logic       sweep_done
);

  // state  | meaning
  // S_IDLE | no sweep; freq_count holds last value
  // S_RUN  | sweeping; prescaler and interval counter run on active pulses
  // S_DONE | one-clk completion, sweep_done asserted, then back to S_IDLE
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] PRE_RELOAD = 8'(PRESCALE - 1);

  state_t     state_q, state_d;
  logic [4:0] start_q, start_d;
  logic [4:0] end_q, end_d;
  logic [7:0] interval_q, interval_d;
  logic [4:0] cur_q, cur_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] icnt_q, icnt_d;
  logic       loop_q, loop_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic ctrl_wr, tick, step;

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    interval_d = interval_q;
    cur_d      = cur_q;
    presc_d    = presc_q;
    icnt_d     = icnt_q;
    loop_d     = loop_q;
    ctrl_wr    = wr && (address == 2'd3);
    tick       = (state_q == S_RUN) && active && (presc_q == 8'd0);
    step       = tick && (icnt_q == 8'd0);

    case (state_q)
      S_RUN: begin
        if (active) presc_d = (presc_q == 8'd0) ? PRE_RELOAD : presc_q - 8'd1;
        if (tick)   icnt_d  = (icnt_q == 8'd0) ? interval_q : icnt_q - 8'd1;
        if (step) begin
          // direction is re-decided every step so a moved end never overshoots
          if (cur_q < end_q)      cur_d = cur_q + 5'd1;
          else if (cur_q > end_q) cur_d = cur_q - 5'd1;
          else if (loop_q)        cur_d = start_q;
          else                    state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    // control writes win over a same-cycle step; counters and cur freeze on abort
    if (ctrl_wr && wdata[2]) begin
      state_d = S_IDLE;
      cur_d   = cur_q;
      presc_d = presc_q;
      icnt_d  = icnt_q;
    end else if (ctrl_wr && wdata[0] && (state_q != S_DONE)) begin
      state_d = S_RUN;
      cur_d   = start_q;
      presc_d = PRE_RELOAD;
      icnt_d  = interval_q;
      loop_d  = wdata[1];
    end

    if (wr) begin
      case (address)
        2'd0:    start_d    = wdata[4:0];
        2'd1:    end_d      = wdata[4:0];
        2'd2:    interval_d = wdata;
        default: ;
      endcase
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      end_q      <= '0;
      interval_q <= '0;
      cur_q      <= '0;
      presc_q    <= '0;
      icnt_q     <= '0;
      loop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      interval_q <= interval_d;
      cur_q      <= cur_d;
      presc_q    <= presc_d;
      icnt_q     <= icnt_d;
      loop_q     <= loop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign freq_count   = cur_q;
  assign noise_enable = busy_q;
  assign busy         = busy_q;
  assign sweep_done   = done_q;

endmodule

// File: tb/tb_wts_noise_sweep_controller.sv
// Bench for wts_noise_sweep_controller: two instances (PRESCALE 1 and 16) share
// stimulus and are checked against a pulse-counting reference model.
module tb_wts_noise_sweep_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] wdata = 8'd0;

  logic [4:0] fc1, fc16;
  logic       ne1, bz1, sd1, ne16, bz16, sd16;
  logic [15:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wts_noise_sweep_controller #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .active(active), .wr(wr), .address(address), .wdata(wdata),
    .freq_count(fc1), .noise_enable(ne1), .busy(bz1), .sweep_done(sd1));

  wts_noise_sweep_controller #(.PRESCALE(16)) dut16 (
    .clk(clk), .reset(reset), .active(active), .wr(wr), .address(address), .wdata(wdata),
    .freq_count(fc16), .noise_enable(ne16), .busy(bz16), .sweep_done(sd16));

  assign obs = {fc1, ne1, bz1, sd1, fc16, ne16, bz16, sd16};

  // Reference: a sweep step happens after (interval+1)*PRESCALE active pulses in RUN.
  typedef struct {
    int st;        // 0 idle, 1 run, 2 done
    int cur, start, endr, interval, loop, pcnt, period;
  } model_t;

  model_t m [2];
  int     pre [2] = '{1, 16};

  function automatic model_t mstep(model_t o, int p, logic rst, logic a, logic w,
                                   logic [1:0] ad, logic [7:0] d);
    model_t n;
    n = o;
    if (rst) begin
      n.st = 0; n.cur = 0; n.start = 0; n.endr = 0; n.interval = 0;
      n.loop = 0; n.pcnt = 0; n.period = 0;
      return n;
    end
    if (o.st == 2) n.st = 0;
    if (w && ad == 2'd3 && d[2]) n.st = 0;
    else if (w && ad == 2'd3 && d[0] && o.st != 2) begin
      n.st = 1; n.cur = o.start; n.pcnt = 0;
      n.period = (o.interval + 1) * p; n.loop = int'(d[1]);
    end else if (o.st == 1 && a) begin
      n.pcnt = o.pcnt + 1;
      if (n.pcnt == o.period) begin
        n.pcnt = 0;
        n.period = (o.interval + 1) * p;
        if (o.cur < o.endr)      n.cur = o.cur + 1;
        else if (o.cur > o.endr) n.cur = o.cur - 1;
        else if (o.loop != 0)    n.cur = o.start;
        else                     n.st = 2;
      end
    end
    if (w) begin
      case (ad)
        2'd0: n.start    = int'(d[4:0]);
        2'd1: n.endr     = int'(d[4:0]);
        2'd2: n.interval = int'(d);
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_vec();
    return {5'(m[0].cur), m[0].st == 1, m[0].st == 1, m[0].st == 2,
            5'(m[1].cur), m[1].st == 1, m[1].st == 1, m[1].st == 2};
  endfunction

  task automatic cycle(input logic a, input logic w, input logic [1:0] ad, input logic [7:0] d);
    active = a; wr = w; address = ad; wdata = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = mstep(m[i], pre[i], reset, a, w, ad, d);
    #1;
    active = 1'b0; wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(0, 0, 2'd0, 8'd0);
    reset = 1'b0;
  endtask

  task automatic setup(input logic [4:0] s, input logic [4:0] e, input logic [7:0] iv);
    cycle(0, 1, 2'd0, {3'd0, s});
    cycle(0, 1, 2'd1, {3'd0, e});
    cycle(0, 1, 2'd2, iv);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (obs !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 16'h0000);
    end
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_up_sweep();
    logic [4:0] exp_seq [4];
    exp_seq = '{5'd3, 5'd4, 5'd5, 5'd6};
    do_reset();
    setup(5'd3, 5'd6, 8'd0);
    cycle(0, 1, 2'd3, 8'h01);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (fc1 !== exp_seq[i] || bz1 !== 1'b1 || sd1 !== 1'b0) begin
        n_fail++; $display("FAIL up_step%0d got fc=%0d busy=%b done=%b exp fc=%0d", i, fc1, bz1, sd1, exp_seq[i]);
      end
      cycle(1, 0, 2'd0, 8'd0);
    end
    n_tests++;
    if (sd1 !== 1'b1 || bz1 !== 1'b0 || ne1 !== 1'b0 || fc1 !== 5'd6) begin
      n_fail++; $display("FAIL up_done got done=%b busy=%b fc=%0d exp done=1 busy=0 fc=6", sd1, bz1, fc1);
    end
    cycle(1, 0, 2'd0, 8'd0);
    n_tests++;
    if (sd1 !== 1'b0 || bz1 !== 1'b0 || fc1 !== 5'd6) begin
      n_fail++; $display("FAIL up_idle got done=%b busy=%b fc=%0d exp 0 0 6", sd1, bz1, fc1);
    end
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL up_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_down_sweep();
    logic [4:0] exp_seq [3];
    exp_seq = '{5'd10, 5'd9, 5'd8};
    do_reset();
    setup(5'd10, 5'd8, 8'd2);
    cycle(0, 1, 2'd3, 8'h01);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 48; k++) begin
        n_tests++;
        if (fc16 !== exp_seq[s] || bz16 !== 1'b1 || ne16 !== 1'b1) begin
          n_fail++; $display("FAIL down_s%0d_k%0d got fc=%0d busy=%b exp fc=%0d busy=1", s, k, fc16, bz16, exp_seq[s]);
        end
        cycle(1, 0, 2'd0, 8'd0);
      end
    end
    n_tests++;
    if (sd16 !== 1'b1 || bz16 !== 1'b0 || fc16 !== 5'd8) begin
      n_fail++; $display("FAIL down_done got done=%b busy=%b fc=%0d exp 1 0 8", sd16, bz16, fc16);
    end
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL down_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_loop_abort();
    logic [4:0] held;
    do_reset();
    setup(5'd0, 5'd2, 8'd0);
    cycle(0, 1, 2'd3, 8'h03);
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (fc1 !== 5'(i % 3) || sd1 !== 1'b0 || bz1 !== 1'b1) begin
        n_fail++; $display("FAIL loop_%0d got fc=%0d done=%b busy=%b exp fc=%0d", i, fc1, sd1, bz1, i % 3);
      end
      cycle(1, 0, 2'd0, 8'd0);
    end
    held = fc1;
    cycle(1, 1, 2'd3, 8'h05);
    n_tests++;
    if (ne1 !== 1'b0 || bz1 !== 1'b0 || sd1 !== 1'b0 || fc1 !== held) begin
      n_fail++; $display("FAIL loop_abort got ne=%b busy=%b done=%b fc=%0d exp 0 0 0 fc=%0d", ne1, bz1, sd1, fc1, held);
    end
    cycle(1, 0, 2'd0, 8'd0);
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL loop_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_end_rewrite();
    do_reset();
    setup(5'd5, 5'd20, 8'd0);
    cycle(0, 1, 2'd3, 8'h01);
    for (int i = 0; i < 4; i++) cycle(1, 0, 2'd0, 8'd0);
    n_tests++;
    if (fc1 !== 5'd9) begin
      n_fail++; $display("FAIL rewrite_pre got fc=%0d exp 9", fc1);
    end
    cycle(0, 1, 2'd1, 8'd4);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 2'd0, 8'd0);
      n_tests++;
      if (fc1 !== 5'(8 - i) || bz1 !== 1'b1) begin
        n_fail++; $display("FAIL rewrite_step%0d got fc=%0d busy=%b exp fc=%0d", i, fc1, bz1, 8 - i);
      end
    end
    cycle(1, 0, 2'd0, 8'd0);
    n_tests++;
    if (sd1 !== 1'b1 || fc1 !== 5'd4) begin
      n_fail++; $display("FAIL rewrite_done got done=%b fc=%0d exp 1 4", sd1, fc1);
    end
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL rewrite_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_go_collision();
    do_reset();
    setup(5'd12, 5'd20, 8'd0);
    cycle(0, 1, 2'd3, 8'h01);
    cycle(1, 0, 2'd0, 8'd0);
    cycle(1, 0, 2'd0, 8'd0);
    cycle(1, 1, 2'd3, 8'h01);
    n_tests++;
    if (fc1 !== 5'd12 || bz1 !== 1'b1) begin
      n_fail++; $display("FAIL collide_restart got fc=%0d busy=%b exp 12 1", fc1, bz1);
    end
    cycle(1, 0, 2'd0, 8'd0);
    cycle(1, 0, 2'd0, 8'd0);
    reset = 1'b1;
    cycle(1, 1, 2'd3, 8'h01);
    reset = 1'b0;
    n_tests++;
    if (obs !== 16'h0000) begin
      n_fail++; $display("FAIL collide_reset got=%h exp=%h", obs, 16'h0000);
    end
    cycle(1, 0, 2'd0, 8'd0);
    n_tests++;
    if (sd1 !== 1'b0 || sd16 !== 1'b0 || bz1 !== 1'b0) begin
      n_fail++; $display("FAIL collide_nodone got done1=%b done16=%b busy=%b exp 0 0 0", sd1, sd16, bz1);
    end
  endtask

  task automatic test_equal();
    do_reset();
    setup(5'd17, 5'd17, 8'd0);
    cycle(0, 1, 2'd3, 8'h01);
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (fc16 !== 5'd17 || bz16 !== 1'b1 || sd16 !== 1'b0) begin
        n_fail++; $display("FAIL equal_k%0d got fc=%0d busy=%b done=%b exp 17 1 0", k, fc16, bz16, sd16);
      end
      cycle(1, 0, 2'd0, 8'd0);
    end
    n_tests++;
    if (sd16 !== 1'b1 || fc16 !== 5'd17) begin
      n_fail++; $display("FAIL equal_done got done=%b fc=%0d exp 1 17", sd16, fc16);
    end
    cycle(1, 0, 2'd0, 8'd0);
    n_tests++;
    if (sd16 !== 1'b0 || bz16 !== 1'b0) begin
      n_fail++; $display("FAIL equal_pulse got done=%b busy=%b exp 0 0", sd16, bz16);
    end
  endtask

  task automatic test_random();
    logic       a, w;
    logic [1:0] ad;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      a  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 5) == 0);
      ad = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      if (ad == 2'd2) d = 8'($urandom_range(0, 3));
      if (ad == 2'd3) begin
        d[0] = ($urandom_range(0, 1) == 0);
        d[2] = ($urandom_range(0, 7) == 0);
      end
      cycle(a, w, ad, d);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) m[i] = mstep(m[i], pre[i], 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_loop_abort();
    test_end_rewrite();
    test_go_collision();
    test_equal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
